uio_nibble_tx: RTL



---
 rtl/uio_nibble_tx_if.sv | 9 +
 rtl/uio_nibble_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uio_nibble_tx_if.sv
// Valid/ready word port between the adder datapath and the nibble transmitter.
interface uio_nibble_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uio_nibble_tx.sv
// Buffers 8-bit result words and ships each one off-chip as two nibbles
// (high first) over the uio pins using a four-phase req/ack handshake.
module uio_nibble_tx #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    uio_nibble_tx_if.slave         in_if,
    input  logic [7:0]             uio_in,
    output logic [7:0]             uio_out,
    output logic [7:0]             uio_oe,
    output logic                   err,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [15:0]   TMO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic [7:0]    word_q, word_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          ack_meta_q, ack_meta_d;
    logic          ack_s_q, ack_s_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          in_ready_q, in_ready_d;
    logic [7:0]    uio_out_q, uio_out_d;
    logic          push_s, pop_s, timeout_s;
    logic [3:0]    nib_s;
    logic          unused_pins;

    assign unused_pins    = ^{uio_in[7:6], uio_in[4:0]};
    assign uio_oe         = 8'b1101_1111;
    assign uio_out        = uio_out_q;
    assign err            = err_q;
    assign level          = level_q;
    assign in_if.in_ready = in_ready_q;

    // Next-state logic for the FIFO, handshake FSM, timeout and pin image.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        mem_d      = mem_q;
        ack_meta_d = uio_in[5];
        ack_s_d    = ack_meta_q;
        timeout_s  = 1'b0;
        pop_s      = 1'b0;
        push_s     = in_if.in_valid & in_ready_q;

        case (state_q)
            IDLE: begin
                if (level_q != {LW{1'b0}}) begin
                    pop_s   = 1'b1;
                    word_d  = mem_q[rd_ptr_q];
                    sel_d   = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                cnt_d   = 16'd0;
                state_d = REQ;
            end
            REQ: begin
                if (ack_s_q) begin
                    cnt_d   = 16'd0;
                    state_d = REL;
                end else if (cnt_q == TMO_LAST) begin
                    timeout_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            REL: begin
                if (!ack_s_q) begin
                    cnt_d = 16'd0;
                    if (sel_q) begin
                        sel_d   = 1'b0;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    timeout_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An abort drops only the word in flight; queued words are kept.
        if (timeout_s) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
        end else begin
            cnt_d = cnt_d;
        end

        if (timeout_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (push_s) begin
            mem_d[wr_ptr_q] = in_if.in_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        in_ready_d = (level_d != FULL_LEVEL);

        if (sel_d) begin
            nib_s = word_d[7:4];
        end else begin
            nib_s = word_d[3:0];
        end

        // Pins are built from next state so they line up with state_q.
        if (state_d != IDLE) begin
            uio_out_d = {1'b1, ~sel_d, 1'b0, (state_d == REQ), nib_s};
        end else begin
            uio_out_d = 8'h00;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            word_q     <= 8'h00;
            cnt_q      <= 16'd0;
            err_q      <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            mem_q      <= '{default: 8'h00};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            level_q    <= {LW{1'b0}};
            in_ready_q <= 1'b1;
            uio_out_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
            uio_out_q  <= uio_out_d;
        end
    end
endmodule
